// File: rtl/prbs_checker_pkg.sv
// Shared LFSR definitions for the PRBS generator/checker pair.
package prbs_checker_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam logic [7:0]  DEF_TAPS  = 8'hB8;

  // Feedback bit: XOR of the tapped register bits (caller masks and zero-extends).
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: locks a local LFSR copy onto the incoming
// stream, then flags mismatches and keeps saturating bit/error counts.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int unsigned       WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS     = WIDTH'(DEF_TAPS),
  parameter int unsigned       LOCK_CNT = 16,
  parameter int unsigned       LOSS_THR = 4,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             din,
  input  logic             din_vld,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             sync_loss
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_THR + 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_sr;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [MISS_W-1:0]  r_miss_cnt;
  logic               r_locked;
  logic               r_err;
  logic               r_sync_loss;

  logic w_pred;
  logic w_match;
  logic w_miss;
  logic w_bit_inc;
  logic w_err_inc;

  assign w_pred    = parity(64'(r_sr & TAPS));
  // An all-zero register predicts 0 forever, so it must never count as a match.
  assign w_match   = (din == w_pred) && (r_sr != '0);
  assign w_miss    = (din != w_pred);
  assign w_bit_inc = din_vld && !clr && (r_state == LOCKED);
  assign w_err_inc = w_bit_inc && w_miss;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_sr        <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_sync_loss <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (clr) begin
        r_state     <= HUNT;
        r_locked    <= 1'b0;
        r_match_cnt <= '0;
        r_miss_cnt  <= '0;
        r_sync_loss <= 1'b0;
      end else if (din_vld) begin
        case (r_state)
          HUNT: begin
            r_sr <= {r_sr[WIDTH-2:0], din};
            if (w_match) begin
              if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                r_state     <= LOCKED;
                r_locked    <= 1'b1;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + MATCH_W'(1);
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Free-running: the prediction, not the received bit, is shifted in.
            r_sr <= {r_sr[WIDTH-2:0], w_pred};
            if (w_miss) begin
              r_err <= 1'b1;
              if (r_miss_cnt == MISS_W'(LOSS_THR - 1)) begin
                r_state     <= HUNT;
                r_locked    <= 1'b0;
                r_sync_loss <= 1'b1;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + MISS_W'(1);
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end
          default: begin
            r_state  <= HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_bit_inc),
    .q     (bit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (w_err_inc),
    .q     (err_cnt)
  );

  assign locked    = r_locked;
  assign err       = r_err;
  assign sync_loss = r_sync_loss;

endmodule
